// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus launch sequencer feeding a slow UART
// transmitter over its txStart/in/txBusy/txDone handshake.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   wr_en, wr_data  producer push of one byte per cycle
//   full, empty     occupancy flags (DEPTH / 0 entries)
//   count           occupancy 0..DEPTH
//   overflow        one-cycle pulse when a push is dropped
//   tx_start        launch request, held until busy is seen
//   tx_data         byte being launched, stable outside IDLE
//   tx_busy         transmitter busy (async, synchronized here)
//   tx_done         transmitter done (observed only)
//   tx_err          sticky watchdog error
//
// Optional feature macro: UART_TXQ_TIMEOUT_EN adds a launch watchdog
// that abandons a byte if busy never rises; tx_err is 0 without it.
module uart_tx_queue #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_busy_m;
    logic              r_busy_s;
    state_t            r_state;

    logic w_push;
    logic w_pop;
    logic w_unused_done;

    // tx_done carries no information the busy handshake lacks.
    assign w_unused_done = tx_done;

    assign count = r_count;
    assign full  = (r_count == L_FULL);
    assign empty = (r_count == '0);

    // full/empty are pre-edge values, so a push into a full FIFO is
    // dropped even when a pop happens on the same edge.
    assign w_push = wr_en & ~full;
    assign w_pop  = (r_state == S_IDLE) & ~empty & ~r_busy_s;

`ifdef UART_TXQ_TIMEOUT_EN
    localparam logic [31:0] L_TMO = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_wdog;
    logic        r_err;
    assign tx_err = r_err;
`else
    localparam int L_UNUSED_TMO = TIMEOUT_CYCLES;
    assign tx_err = 1'b0;
`endif

    // Storage has no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_busy_m <= 1'b0;
            r_busy_s <= 1'b0;
            r_state  <= S_IDLE;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
`ifdef UART_TXQ_TIMEOUT_EN
            r_wdog   <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_busy_m <= tx_busy;
            r_busy_s <= r_busy_m;
            overflow <= wr_en & full;

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                tx_data <= r_mem[r_rptr];
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    tx_start <= 1'b0;
                    if (w_pop) begin
                        tx_start <= 1'b1;
                        r_state  <= S_LAUNCH;
`ifdef UART_TXQ_TIMEOUT_EN
                        r_wdog   <= '0;
`endif
                    end
                end
                S_LAUNCH: begin
                    // Hold start until the transmitter has seen it on
                    // its own baud clock, which busy proves.
                    if (r_busy_s) begin
                        tx_start <= 1'b0;
                        r_state  <= S_WAIT;
                    end
`ifdef UART_TXQ_TIMEOUT_EN
                    else if (r_wdog == L_TMO) begin
                        tx_start <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= S_GAP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                S_WAIT: begin
                    tx_start <= 1'b0;
                    if (!r_busy_s) begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    tx_start <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue with a simple
// transmitter model answering tx_start with a delayed busy pulse.
module tb_uart_tx_queue;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    wire        tx_busy;
    logic       tx_done;
    logic       tx_err;

    logic force_busy;
    logic m_busy;
    logic m_act;
    logic model_en;
    logic chk_gap;
    int   lat;
    int   dur;
    int   n_sent;
    int   n_cmp;
    int   n_bad;

    logic [7:0] sb [$];

    assign tx_busy = force_busy | m_busy;

    uart_tx_queue #(
        .DEPTH(16),
        .ADDR_W(4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit exp_ok);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        check("push_ovf", 32'(overflow), 32'(!exp_ok));
        if (exp_ok) sb.push_back(d);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || m_act || !empty) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_in_time", 32'(k < budget), 1);
        repeat (8) @(negedge clk);
        check("drain_count", 32'(count), 0);
        check("drain_start", 32'(tx_start), 0);
    endtask

    // Transmitter model: busy rises lat cycles after seeing tx_start,
    // stays up dur cycles.
    initial begin
        int n;
        m_busy = 1'b0;
        m_act  = 1'b0;
        n_sent = 0;
        forever begin
            @(negedge clk);
            if (model_en && tx_start === 1'b1 && !rst) begin
                m_act = 1'b1;
                if (sb.size() == 0)
                    check("spurious_launch", 32'(tx_data), 32'hFFFF);
                else
                    check("tx_order", 32'(tx_data), 32'(sb.pop_front()));
                n_sent++;
                repeat (lat) @(negedge clk);
                m_busy = 1'b1;
                @(negedge clk);
                check("start_hold1", 32'(tx_start), 1);
                @(negedge clk);
                check("start_hold2", 32'(tx_start), 1);
                @(negedge clk);
                check("start_drop", 32'(tx_start), 0);
                repeat (dur - 3) @(negedge clk);
                m_busy = 1'b0;
                if (chk_gap && sb.size() != 0) begin
                    n = 0;
                    while (n < 20 && tx_start !== 1'b1) begin
                        @(negedge clk);
                        n++;
                    end
                    check("gap_latency", 32'(n), 5);
                end
                m_act = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int n;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        tx_done    = 1'b0;
        force_busy = 1'b0;
        model_en   = 1'b0;
        chk_gap    = 1'b0;
        lat        = 4;
        dur        = 10;

        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_start", 32'(tx_start), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_err", 32'(tx_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a launch with 5 bytes still queued.
        for (int i = 1; i <= 6; i++) push(8'(8'h10 + i), 1'b1);
        check("pre_rst_count", 32'(count), 5);
        check("pre_rst_start", 32'(tx_start), 1);
        check("pre_rst_data", 32'(tx_data), 32'h11);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_start", 32'(tx_start), 0);
        check("mid_rst_data", 32'(tx_data), 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_en = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_idle", 32'(tx_start), 0);
        check("post_rst_count", 32'(count), 0);

        // Single byte with a slow transmitter, then gap to the next.
        lat     = 40;
        dur     = 200;
        chk_gap = 1'b1;
        push(8'hA5, 1'b1);
        push(8'h5A, 1'b1);
        drain(3000);
        chk_gap = 1'b0;
        lat     = 4;
        dur     = 10;

        // Burst to full, overflow, then push dropped on the pop edge.
        base       = n_sent;
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
        check("burst_full", 32'(full), 1);
        check("burst_count", 32'(count), 16);
        push(8'hFF, 1'b0);
        check("burst_count_hold", 32'(count), 16);
        @(negedge clk);
        check("ovf_pulse_end", 32'(overflow), 0);
        force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check("fullpop_ovf", 32'(overflow), 1);
        check("fullpop_count", 32'(count), 15);
        drain(2000);
        check("burst_sent", 32'(n_sent - base), 16);

        // Push on the same edge as a pop with 3 queued.
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        push(8'h31, 1'b1);
        push(8'h32, 1'b1);
        push(8'h33, 1'b1);
        check("simul_pre_count", 32'(count), 3);
        force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h34;
        @(negedge clk);
        wr_en = 1'b0;
        sb.push_back(8'h34);
        check("simul_count", 32'(count), 3);
        check("simul_start", 32'(tx_start), 1);
        check("simul_ovf", 32'(overflow), 0);
        drain(2000);

        // Pointer wrap: 40 random bytes in bursts of 8.
        base = n_sent;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)), 1'b1);
            repeat (220) @(negedge clk);
        end
        drain(3000);
        check("wrap_sent", 32'(n_sent - base), 40);

`ifdef UART_TXQ_TIMEOUT_EN
        model_en = 1'b0;
        push(8'hC1, 1'b1);
        push(8'hC2, 1'b1);
        n = 0;
        while (tx_start === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_len", 32'(n), 50);
        check("tmo_err", 32'(tx_err), 1);
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("tmo_next_launch", 32'(tx_start), 1);
        check("tmo_next_data", 32'(tx_data), 32'hC2);
        check("tmo_err_sticky", 32'(tx_err), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("tmo_err_clr", 32'(tx_err), 0);
`else
        n = 0;
        check("err_tied", 32'(tx_err), 32'(n));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
